enc_quad_counter: RTL and testbench



---
 rtl/enc_pkg.sv | 43 ++++
 rtl/enc_glitch_filter.sv | 63 ++++++
 rtl/enc_quad_counter.sv | 169 ++++++++++++++++
 tb/tb_enc_quad_counter.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/enc_pkg.sv
// Shared definitions for the quadrature encoder front end.
//   - direction codes reported on motor_dir
//   - position/revolution word width
//   - quadrature step classification for a {prev_AB, cur_AB} pair
//   - packed bundle of the three filtered encoder lines
package enc_pkg;

    localparam int unsigned POS_W = 16;
    localparam int unsigned DIR_W = 2;

    localparam logic [DIR_W-1:0] DIR_STOP = 2'b00;
    localparam logic [DIR_W-1:0] DIR_FWD  = 2'b01;
    localparam logic [DIR_W-1:0] DIR_REV  = 2'b10;

    // Classification of one clock's change on the filtered {A,B} pair
    typedef enum logic [1:0] {
        STEP_NONE = 2'b00,
        STEP_FWD  = 2'b01,
        STEP_REV  = 2'b10,
        STEP_ERR  = 2'b11
    } step_e;

    // Filtered encoder lines
    typedef struct packed {
        logic a;
        logic b;
        logic z;
    } enc_lines_t;

    // Forward order is 00 -> 10 -> 11 -> 01 -> 00 on {A,B}; a change of both bits is illegal
    function automatic step_e step_lookup(input logic [1:0] prev_ab, input logic [1:0] cur_ab);
        step_e s;
        s = STEP_NONE;
        case ({prev_ab, cur_ab})
            4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: s = STEP_FWD;
            4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: s = STEP_REV;
            4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: s = STEP_ERR;
            default:                                s = STEP_NONE;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/enc_glitch_filter.sv
// Two-flop synchroniser followed by a run-counter glitch filter for one
// asynchronous encoder line. The stable level flips only after FILT_LEN
// consecutive clocks in which the synchronised input disagrees with it.
//   clk     encoder clock
//   rst_n   asynchronous active-low reset
//   raw_i   asynchronous encoder line
//   filt_o  registered filtered level
module enc_glitch_filter #(
    parameter int unsigned FILT_LEN = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_i,
    output logic filt_o
);

    localparam int unsigned RUN_W = 4;

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             level_d;
    logic [RUN_W-1:0] run_q;
    logic [RUN_W-1:0] run_d;

    // Metastability synchroniser
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
        end
    end

    // Run counter: the FILT_LEN-th consecutive mismatch flips the level
    always_comb begin
        level_d = level_q;
        run_d   = '0;
        if (sync2_q != level_q) begin
            if (run_q == RUN_W'(FILT_LEN - 1)) begin
                level_d = ~level_q;
                run_d   = '0;
            end else begin
                run_d = run_q + RUN_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= 1'b0;
            run_q   <= '0;
        end else begin
            level_q <= level_d;
            run_q   <= run_d;
        end
    end

    assign filt_o = level_q;

endmodule

// File: rtl/enc_quad_counter.sv
// Quadrature encoder front end: filters A/B/Z, decodes x4 steps and keeps
// the in-revolution position, the revolution count, the direction and the
// homing state. All outputs come straight from flops.
//   clk        encoder clock (50 MHz)
//   rst_n      asynchronous active-low reset (PLL locked)
//   Enco_A/B   asynchronous quadrature lines
//   Enco_Z     asynchronous index line
//   motor_cnt  position within the revolution, 0..ENCO_NUM-1
//   motor_cir  signed revolution count, wraps silently
//   motor_dir  00 stopped, 01 forward, 10 reverse
//   homed      set by the first filtered Z rising edge after reset
//   step_err   one-clock pulse on an illegal A/B transition
module enc_quad_counter
    import enc_pkg::*;
#(
    parameter int unsigned ENCO_NUM = 4000,
    parameter int unsigned FILT_LEN = 4,
    parameter int unsigned STOP_CYC = 50000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    Enco_A,
    input  logic                    Enco_B,
    input  logic                    Enco_Z,
    output logic signed [POS_W-1:0] motor_cnt,
    output logic signed [POS_W-1:0] motor_cir,
    output logic [DIR_W-1:0]        motor_dir,
    output logic                    homed,
    output logic                    step_err
);

    localparam int unsigned IDLE_W = (STOP_CYC > 1) ? $clog2(STOP_CYC) : 1;
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(STOP_CYC - 1);
    localparam logic [POS_W-1:0]  CNT_MAX  = POS_W'(ENCO_NUM - 1);

    logic        filt_a;
    logic        filt_b;
    logic        filt_z;
    enc_lines_t  filt;
    enc_lines_t  prev_q;

    logic [POS_W-1:0]  cnt_q;
    logic [POS_W-1:0]  cnt_d;
    logic [POS_W-1:0]  cir_q;
    logic [POS_W-1:0]  cir_d;
    logic [DIR_W-1:0]  dir_q;
    logic [DIR_W-1:0]  dir_d;
    logic [IDLE_W-1:0] idle_q;
    logic [IDLE_W-1:0] idle_d;
    logic              homed_q;
    logic              homed_d;
    logic              err_q;
    logic              err_d;

    step_e step_c;
    logic  valid_step_c;
    logic  home_c;

    // One synchroniser + filter per encoder line
    enc_glitch_filter #(.FILT_LEN(FILT_LEN)) u_filt_a (
        .clk    (clk),
        .rst_n  (rst_n),
        .raw_i  (Enco_A),
        .filt_o (filt_a)
    );

    enc_glitch_filter #(.FILT_LEN(FILT_LEN)) u_filt_b (
        .clk    (clk),
        .rst_n  (rst_n),
        .raw_i  (Enco_B),
        .filt_o (filt_b)
    );

    enc_glitch_filter #(.FILT_LEN(FILT_LEN)) u_filt_z (
        .clk    (clk),
        .rst_n  (rst_n),
        .raw_i  (Enco_Z),
        .filt_o (filt_z)
    );

    assign filt = '{a: filt_a, b: filt_b, z: filt_z};

    // Step classification against last clock's filtered levels
    assign step_c       = step_lookup({prev_q.a, prev_q.b}, {filt.a, filt.b});
    assign valid_step_c = (step_c == STEP_FWD) || (step_c == STEP_REV);
    assign home_c       = filt.z && !prev_q.z && !homed_q;

    // Position, revolution, direction, idle and homing update
    always_comb begin
        cnt_d   = cnt_q;
        cir_d   = cir_q;
        dir_d   = dir_q;
        idle_d  = idle_q;
        homed_d = homed_q;
        err_d   = 1'b0;

        case (step_c)
            STEP_FWD: begin
                dir_d  = DIR_FWD;
                idle_d = '0;
                if (cnt_q == CNT_MAX) begin
                    cnt_d = '0;
                    cir_d = cir_q + POS_W'(1);
                end else begin
                    cnt_d = cnt_q + POS_W'(1);
                end
            end
            STEP_REV: begin
                dir_d  = DIR_REV;
                idle_d = '0;
                if (cnt_q == '0) begin
                    cnt_d = CNT_MAX;
                    cir_d = cir_q - POS_W'(1);
                end else begin
                    cnt_d = cnt_q - POS_W'(1);
                end
            end
            STEP_ERR: begin
                err_d = 1'b1;
            end
            default: begin
                err_d = 1'b0;
            end
        endcase

        // Counter parks at STOP_CYC-1; the next idle clock reports stopped
        if (!valid_step_c) begin
            if (idle_q == IDLE_MAX) begin
                dir_d = DIR_STOP;
            end else begin
                idle_d = idle_q + IDLE_W'(1);
            end
        end

        // First index wins over a coincident step; revolution count is kept
        if (home_c) begin
            cnt_d   = '0;
            cir_d   = cir_q;
            homed_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q  <= '0;
            cnt_q   <= '0;
            cir_q   <= '0;
            dir_q   <= DIR_STOP;
            idle_q  <= '0;
            homed_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            prev_q  <= filt;
            cnt_q   <= cnt_d;
            cir_q   <= cir_d;
            dir_q   <= dir_d;
            idle_q  <= idle_d;
            homed_q <= homed_d;
            err_q   <= err_d;
        end
    end

    assign motor_cnt = cnt_q;
    assign motor_cir = cir_q;
    assign motor_dir = dir_q;
    assign homed     = homed_q;
    assign step_err  = err_q;

endmodule

// File: tb/tb_enc_quad_counter.sv
// Bench for enc_quad_counter: a per-clock reference model pushes the
// expected output snapshot after every clock edge; a negedge monitor pops
// and compares. Directed scenarios add fixed-value checks.
module tb_enc_quad_counter;

    localparam int unsigned ENC  = 8;
    localparam int unsigned FL   = 4;
    localparam int unsigned STOP = 100;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic enc_a = 1'b0;
    logic enc_b = 1'b0;
    logic enc_z = 1'b0;
    logic [1:0] ab = 2'b00;

    logic signed [15:0] motor_cnt;
    logic signed [15:0] motor_cir;
    logic [1:0]         motor_dir;
    logic               homed;
    logic               step_err;

    enc_quad_counter #(.ENCO_NUM(ENC), .FILT_LEN(FL), .STOP_CYC(STOP)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .Enco_A    (enc_a),
        .Enco_B    (enc_b),
        .Enco_Z    (enc_z),
        .motor_cnt (motor_cnt),
        .motor_cir (motor_cir),
        .motor_dir (motor_dir),
        .homed     (homed),
        .step_err  (step_err)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [15:0] cnt;
        logic [15:0] cir;
        logic [1:0]  dir;
        logic        homed;
        logic        err;
    } snap_t;

    snap_t exp_q[$];
    logic  ha[$];
    logic  hb[$];
    logic  hz[$];
    logic  fa, fb, fz, pa, pb, pz;
    int    m_cnt;
    shortint m_cir;
    logic [1:0] m_dir;
    logic  m_homed;
    int    m_age;

    // Quadrature phase index: 00=0, 10=1, 11=2, 01=3
    function automatic int gpos(input logic a, input logic b);
        if (!a && !b) return 0;
        if (a && !b)  return 1;
        if (a && b)   return 2;
        return 3;
    endfunction

    function automatic logic [1:0] gcode(input int p);
        case (p)
            0:       return 2'b00;
            1:       return 2'b10;
            2:       return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

    // A level is accepted once the FL samples seen by the filter all disagree with it.
    // h[0] is the pin sampled this edge; the filter sees it two edges later.
    function automatic logic accept(input logic stable, input logic h[$]);
        for (int j = 2; j < int'(FL) + 2; j++)
            if (h[j] == stable) return stable;
        return ~stable;
    endfunction

    task automatic m_reset();
        ha.delete(); hb.delete(); hz.delete();
        for (int j = 0; j < int'(FL) + 2; j++) begin
            ha.push_back(1'b0); hb.push_back(1'b0); hz.push_back(1'b0);
        end
        fa = 0; fb = 0; fz = 0; pa = 0; pb = 0; pz = 0;
        m_cnt = 0; m_cir = 0; m_dir = 2'b00; m_homed = 0; m_age = 0;
        exp_q.delete();
    endtask

    always @(posedge clk or negedge rst_n) begin : model
        int   d;
        logic m_err;
        logic home;
        if (!rst_n) begin
            m_reset();
        end else begin
            ha.push_front(enc_a); hb.push_front(enc_b); hz.push_front(enc_z);
            void'(ha.pop_back()); void'(hb.pop_back()); void'(hz.pop_back());
            d     = (gpos(fa, fb) - gpos(pa, pb) + 4) % 4;
            home  = fz && !pz && !m_homed;
            m_err = (d == 2);
            if (d == 1 || d == 3) begin
                m_age = 0;
                m_dir = (d == 1) ? 2'b01 : 2'b10;
                if (!home) begin
                    m_cnt = m_cnt + ((d == 1) ? 1 : -1);
                    if (m_cnt == int'(ENC)) begin m_cnt = 0; m_cir++; end
                    if (m_cnt < 0) begin m_cnt = int'(ENC) - 1; m_cir--; end
                end
            end else begin
                if (m_age < int'(STOP)) m_age++;
                if (m_age == int'(STOP)) m_dir = 2'b00;
            end
            if (home) begin
                m_cnt   = 0;
                m_homed = 1'b1;
            end
            pa = fa; pb = fb; pz = fz;
            fa = accept(fa, ha); fb = accept(fb, hb); fz = accept(fz, hz);
            exp_q.push_back('{cnt: 16'(m_cnt), cir: m_cir, dir: m_dir, homed: m_homed, err: m_err});
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin : monitor
        snap_t s;
        if (rst_n) begin
            chk("sb_depth", exp_q.size(), 1);
            if (exp_q.size() > 0) begin
                s = exp_q.pop_front();
                chk("sb_cnt",   int'(motor_cnt), int'($signed(s.cnt)));
                chk("sb_cir",   int'(motor_cir), int'($signed(s.cir)));
                chk("sb_dir",   int'(motor_dir), int'(s.dir));
                chk("sb_homed", int'(homed),     int'(s.homed));
                chk("sb_err",   int'(step_err),  int'(s.err));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [1:0] next_ab(input logic [1:0] cur, input bit fwd);
        return gcode((gpos(cur[1], cur[0]) + (fwd ? 1 : 3)) % 4);
    endfunction

    task automatic drive_ab(input logic [1:0] v);
        enc_a = v[1]; enc_b = v[0]; ab = v;
    endtask

    task automatic step1(input bit fwd, input int hold);
        @(negedge clk);
        drive_ab(next_ab(ab, fwd));
        repeat (hold - 1) @(negedge clk);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_cnt"},   int'(motor_cnt), 0);
        chk({tag, "_cir"},   int'(motor_cir), 0);
        chk({tag, "_dir"},   int'(motor_dir), 0);
        chk({tag, "_homed"}, int'(homed),     0);
        chk({tag, "_err"},   int'(step_err),  0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1 rst_n = 1'b0;
        drive_ab(2'b00);
        enc_z = 1'b0;
        #1 chk_zero("rst");
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    // Drive one step and report the edge index (0 = sampling edge) at which motor_cnt moved
    task automatic step_lat(input bit fwd, output int lat);
        logic signed [15:0] c0;
        c0 = motor_cnt;
        @(negedge clk);
        drive_ab(next_ab(ab, fwd));
        lat = -1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (lat < 0 && motor_cnt != c0) lat = i;
        end
    endtask

    task automatic glitch_a(input int len, output int errs, output int changed, output int dcnt);
        logic signed [15:0] c0;
        c0 = motor_cnt; errs = 0; changed = 0;
        @(negedge clk);
        enc_a = ~enc_a;
        for (int i = 0; i < len + 25; i++) begin
            @(negedge clk);
            if (i == len - 1) enc_a = ~enc_a;
            if (step_err) errs++;
            if (motor_cnt != c0) changed = 1;
        end
        dcnt = int'(motor_cnt) - int'(c0);
    endtask

    // ---------------- main sequence ----------------
    initial begin : main
        int lat, e, s, errs, changed, dcnt;
        logic signed [15:0] c0;
        logic [1:0] d0, nx;

        repeat (4) @(negedge clk);
        do_reset();

        // 32 clean forward steps, latency on each
        for (int i = 0; i < 32; i++) begin
            step_lat(1'b1, lat);
            chk("step_latency", lat, int'(FL) + 2);
        end
        chk("fwd32_cnt", int'(motor_cnt), 0);
        chk("fwd32_cir", int'(motor_cir), 4);
        chk("fwd32_dir", int'(motor_dir), 1);

        // Idle timeout measured from the step's output edge
        c0 = motor_cnt;
        @(negedge clk);
        drive_ab(next_ab(ab, 1'b1));
        e = -1; s = -1;
        for (int i = 0; i < int'(STOP) + 40; i++) begin
            @(posedge clk); #1;
            if (e < 0 && motor_cnt != c0) e = i;
            if (e >= 0 && s < 0 && motor_dir == 2'b00) s = i;
        end
        chk("stop_gap", s - e, int'(STOP));
        chk("stop_cnt", int'(motor_cnt), 1);

        // Wrap forward then back through zero
        do_reset();
        repeat (9) step1(1'b1, 20);
        chk("wrapf_cnt", int'(motor_cnt), 1);
        chk("wrapf_cir", int'(motor_cir), 1);
        chk("wrapf_dir", int'(motor_dir), 1);
        repeat (10) step1(1'b0, 20);
        repeat (10) @(negedge clk);
        chk("wrapr_cnt", int'(motor_cnt), 7);
        chk("wrapr_cir", int'(motor_cir), -1);
        chk("wrapr_dir", int'(motor_dir), 2);

        // Glitch rejection and minimum accepted pulse
        glitch_a(3, errs, changed, dcnt);
        chk("glitch3_changed", changed, 0);
        chk("glitch3_err", errs, 0);
        glitch_a(4, errs, changed, dcnt);
        chk("pulse4_changed", changed, 1);
        chk("pulse4_net", dcnt, 0);
        chk("pulse4_err", errs, 0);

        // Illegal 00 -> 11
        for (int i = 0; i < 4 && ab != 2'b00; i++) step1(1'b1, 20);
        c0 = motor_cnt; d0 = motor_dir; errs = 0;
        @(negedge clk);
        drive_ab(2'b11);
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (step_err) errs++;
        end
        chk("illegal_err_cycles", errs, 1);
        chk("illegal_cnt", int'(motor_cnt), int'(c0));
        chk("illegal_dir", int'(motor_dir), int'(d0));

        // Homing and later index ignored
        do_reset();
        repeat (5) step1(1'b1, 20);
        chk("prehome_cnt", int'(motor_cnt), 5);
        chk("prehome_homed", int'(homed), 0);
        @(negedge clk); enc_z = 1'b1;
        repeat (20) @(negedge clk);
        chk("home_cnt", int'(motor_cnt), 0);
        chk("home_homed", int'(homed), 1);
        enc_z = 1'b0;
        repeat (10) @(negedge clk);
        repeat (3) step1(1'b1, 20);
        enc_z = 1'b1;
        repeat (20) @(negedge clk);
        chk("z2_cnt", int'(motor_cnt), 3);
        enc_z = 1'b0;

        // Index coincident with a forward step
        do_reset();
        repeat (2) step1(1'b1, 20);
        @(negedge clk);
        drive_ab(next_ab(ab, 1'b1));
        enc_z = 1'b1;
        repeat (20) @(negedge clk);
        chk("zstep_cnt", int'(motor_cnt), 0);
        chk("zstep_homed", int'(homed), 1);
        chk("zstep_dir", int'(motor_dir), 1);
        chk("zstep_cir", int'(motor_cir), 0);
        enc_z = 1'b0;

        // Asynchronous reset mid-motion
        repeat (3) step1(1'b0, 20);
        @(negedge clk);
        drive_ab(next_ab(ab, 1'b0));
        repeat (int'(FL) + 2) @(posedge clk);
        #3 rst_n = 1'b0;
        #1 chk_zero("midrst");
        drive_ab(2'b00);
        enc_z = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;

        // Randomised traffic
        for (int it = 0; it < 400; it++) begin
            if (it == 200) do_reset();
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: step1(1'($urandom_range(0, 1)), int'($urandom_range(1, 12)));
                6: begin
                    for (int k = 0; k < int'($urandom_range(1, 6)); k++) begin
                        @(negedge clk);
                        drive_ab(2'($urandom_range(0, 3)));
                    end
                end
                7: begin
                    @(negedge clk);
                    enc_z = ~enc_z;
                end
                8: begin
                    nx = ab ^ 2'b11;
                    @(negedge clk);
                    drive_ab(nx);
                    repeat (9) @(negedge clk);
                end
                default: repeat (int'($urandom_range(1, 30))) @(negedge clk);
            endcase
        end
        repeat (20) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks so far", n_pass, n_total);
        $fatal(1, "timeout");
    end

endmodule
